gray_counter: RTL and testbench

//   Synchronous up/down counter that produces registered Gray-code words,

---
 rtl/gray_counter.sv | 98 +++++++++
 tb/tb_gray_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Up/down binary counter with registered Gray-code output,
//                registered binary output, change and terminal-count pulses.
//                Optional macro GRAY_SAT_EN turns modulo wrap into saturation
//                (wrap then flags a step blocked at the limit).
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             changed,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);
    localparam logic [WIDTH-1:0] c_MAX        = '1;
    localparam logic [WIDTH-1:0] c_MIN        = '0;
    localparam logic [WIDTH-1:0] c_ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_changed;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_wrap;
    logic             w_next_changed;

    // Next-state selection: load beats a count step; the limit cases set wrap.
    always_comb begin
        w_next_bin  = r_bin;
        w_next_wrap = 1'b0;
        if (load) begin
            w_next_bin = load_val;
        end else if (en) begin
            if (up_dn) begin
                if (r_bin == c_MAX) begin
`ifdef GRAY_SAT_EN
                    w_next_bin = r_bin;
`else
                    w_next_bin = c_MIN;
`endif
                    w_next_wrap = 1'b1;
                end else begin
                    w_next_bin = r_bin + c_ONE;
                end
            end else begin
                if (r_bin == c_MIN) begin
`ifdef GRAY_SAT_EN
                    w_next_bin = r_bin;
`else
                    w_next_bin = c_MAX;
`endif
                    w_next_wrap = 1'b1;
                end else begin
                    w_next_bin = r_bin - c_ONE;
                end
            end
        end
        // Gray is derived from the next binary value so both register together.
        w_next_gray    = w_next_bin ^ (w_next_bin >> 1);
        w_next_changed = (w_next_gray != r_gray);
    end

    // State and output registers; reset aborts any pending step immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin     <= RESET_VAL;
            r_gray    <= c_RESET_GRAY;
            r_changed <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_bin     <= w_next_bin;
            r_gray    <= w_next_gray;
            r_changed <= w_next_changed;
            r_wrap    <= w_next_wrap;
        end
    end

    assign gray    = r_gray;
    assign bin     = r_bin;
    assign changed = r_changed;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_counter
//  Description : Directed self-checking bench for gray_counter (WIDTH=4),
//                with a Gray-to-binary converter model chained on gray.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             up_dn = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic             changed;
    logic             wrap;

    int n_total = 0;
    int n_pass  = 0;

    gray_counter #(.WIDTH(WIDTH), .RESET_VAL(4'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .gray     (gray),
        .bin      (bin),
        .changed  (changed),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [3:0] up_seq [15] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111,
                                4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin
        logic [WIDTH-1:0] prev_gray;
        logic [WIDTH-1:0] m_bin;
        logic [WIDTH-1:0] m_prev;
        logic             m_wrap;

        // Reset held over two edges, released away from the edge
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_gray", 32'(gray), 32'h0);
        check("rst_bin", 32'(bin), 32'h0);
        check("rst_changed", 32'(changed), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);

        // 15 up steps through the full Gray sequence
        prev_gray = 4'b0000;
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("up_gray", 32'(gray), 32'(up_seq[i]));
            check("up_bin", 32'(bin), 32'(i + 1));
            check("up_changed", 32'(changed), 32'h1);
            check("up_wrap", 32'(wrap), 32'h0);
            check("up_onebit", 32'($countones(gray ^ prev_gray)), 32'h1);
            prev_gray = gray;
        end

`ifdef GRAY_SAT_EN
        // Saturation at 1111: three blocked steps, then one step down
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_bin", 32'(bin), 32'hF);
            check("sat_gray", 32'(gray), 32'h8);
            check("sat_wrap", 32'(wrap), 32'h1);
            check("sat_changed", 32'(changed), 32'h0);
        end
        up_dn = 1'b0;
        tick();
        check("sat_dn_bin", 32'(bin), 32'hE);
        check("sat_dn_gray", 32'(gray), 32'h9);
        check("sat_dn_wrap", 32'(wrap), 32'h0);
        check("sat_dn_changed", 32'(changed), 32'h1);
`else
        // Wrap up from 1111, then wrap down from 0000
        tick();
        check("wrap_up_bin", 32'(bin), 32'h0);
        check("wrap_up_gray", 32'(gray), 32'h0);
        check("wrap_up_wrap", 32'(wrap), 32'h1);
        check("wrap_up_changed", 32'(changed), 32'h1);
        up_dn = 1'b0;
        tick();
        check("wrap_dn_bin", 32'(bin), 32'hF);
        check("wrap_dn_gray", 32'(gray), 32'h8);
        check("wrap_dn_wrap", 32'(wrap), 32'h1);
`endif

        // Idle cycle: hold, no pulses
        en = 1'b0;
        prev_gray = gray;
        tick();
        check("idle_gray", 32'(gray), 32'(prev_gray));
        check("idle_changed", 32'(changed), 32'h0);
        check("idle_wrap", 32'(wrap), 32'h0);

        // Load with en/up in the same cycle: load wins
        load = 1'b1; load_val = 4'b0110; en = 1'b1; up_dn = 1'b1;
        tick();
        check("load_bin", 32'(bin), 32'h6);
        check("load_gray", 32'(gray), 32'h5);
        check("load_wrap", 32'(wrap), 32'h0);
        check("load_changed", 32'(changed), 32'h1);
        // Reload same value: no change
        tick();
        check("reload_bin", 32'(bin), 32'h6);
        check("reload_changed", 32'(changed), 32'h0);
        // Load at 1111 with en/up: would wrap if the step were taken
        load_val = 4'b1111;
        tick();
        tick();
        check("load_max_bin", 32'(bin), 32'hF);
        check("load_max_wrap", 32'(wrap), 32'h0);

        // Reach 0101, then async reset between edges
        load_val = 4'b0100;
        tick();
        load = 1'b0;
        tick();
        check("pre_rst_bin", 32'(bin), 32'h5);
        check("pre_rst_gray", 32'(gray), 32'h7);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_bin", 32'(bin), 32'h0);
        check("async_rst_gray", 32'(gray), 32'h0);
        check("async_rst_changed", 32'(changed), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("resume_bin", 32'(bin), 32'h1);
        check("resume_gray", 32'(gray), 32'h1);

        // Random traffic with converter chained on gray
        m_bin = 4'd1;
        for (int i = 0; i < 100; i++) begin
            en       = 1'($urandom_range(0, 1));
            up_dn    = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
            m_prev = m_bin;
            m_wrap = 1'b0;
            if (load) begin
                m_bin = load_val;
            end else if (en) begin
                if (up_dn && m_bin == 4'hF) begin
                    m_wrap = 1'b1;
`ifndef GRAY_SAT_EN
                    m_bin = 4'h0;
`endif
                end else if (!up_dn && m_bin == 4'h0) begin
                    m_wrap = 1'b1;
`ifndef GRAY_SAT_EN
                    m_bin = 4'hF;
`endif
                end else if (up_dn) begin
                    m_bin = m_bin + 4'd1;
                end else begin
                    m_bin = m_bin - 4'd1;
                end
            end
            tick();
            check("rnd_conv", 32'(g2b(gray)), 32'(bin));
            check("rnd_bin", 32'(bin), 32'(m_bin));
            check("rnd_wrap", 32'(wrap), 32'(m_wrap));
            check("rnd_changed", 32'(changed), 32'(b2g(m_bin) != b2g(m_prev)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
